// File: rtl/arm_pkg.sv
// arm_pkg: constants and fetch FSM state type shared by the fetch stage.
package arm_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/arm_fetch_fifo.sv
// arm_fetch_fifo: synchronous prefetch FIFO with flush and occupancy count (DEPTH must be a power of 2).
module arm_fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [W-1:0]              i_data,
  input  logic                      i_pop,
  output logic [W-1:0]              o_data,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  assign o_data = r_mem[r_rd];
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk)
    if (rst || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(i_push);
      r_rd <= r_rd + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  always_ff @(posedge clk)
    if (!rst && !i_flush) begin
      assert (!(i_push && !i_pop && r_cnt == (AW+1)'(DEPTH)));
      assert (!(i_pop && !i_push && o_empty));
    end
endmodule

// File: rtl/arm_fetch.sv
// arm_fetch: fetch PC, credit-limited instruction reads, prefetch FIFO and redirect squashing.
// Define ARM_FETCH_BYPASS_EN to hand a response straight to the decoder when the FIFO is empty.
module arm_fetch import arm_pkg::*; #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] MAXC = CW'(FIFO_DEPTH);
  fetch_state_e r_state;
  logic [31:0] r_fetch_pc, r_ret_pc, w_redir_pc;
  logic [CW-1:0] r_outst, r_squash, w_count, w_outst_nxt, w_squash_nxt;
  logic [63:0] w_head;
  logic w_empty, w_grant, w_take, w_bypass, w_push, w_pop;
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign imem_req = !reset && r_state == RUN && !redirect_valid && ({1'b0, r_outst} + {1'b0, w_count} < {1'b0, MAXC});
  assign imem_addr = r_fetch_pc;
  assign w_grant = imem_req && imem_gnt;
  assign w_take = imem_rvalid && r_squash == '0;
`ifdef ARM_FETCH_BYPASS_EN
  assign w_bypass = w_take && w_empty && inst_ready && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = w_take && !w_bypass && !redirect_valid;
  assign inst_valid = !redirect_valid && (!w_empty || w_bypass);
  assign w_pop = inst_valid && inst_ready && !w_empty;
  assign inst = w_bypass ? imem_rdata : w_empty ? '0 : w_head[63:32];
  assign inst_pc = w_bypass ? r_ret_pc : w_empty ? '0 : w_head[31:0];
  // A redirect marks every read still in flight after this edge as stale.
  assign w_outst_nxt = r_outst + CW'(w_grant) - CW'(imem_rvalid);
  assign w_squash_nxt = redirect_valid ? w_outst_nxt : r_squash - CW'(imem_rvalid && r_squash != '0);
  arm_fetch_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  ({imem_rdata, r_ret_pc}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= RUN;
      r_fetch_pc <= RESET_PC;
      r_ret_pc <= RESET_PC;
      r_outst <= '0;
      r_squash <= '0;
    end else begin
      r_state <= w_squash_nxt != '0 ? DRAIN : RUN;
      r_outst <= w_outst_nxt;
      r_squash <= w_squash_nxt;
      r_fetch_pc <= redirect_valid ? w_redir_pc : w_grant ? r_fetch_pc + WORD_BYTES : r_fetch_pc;
      r_ret_pc <= redirect_valid ? w_redir_pc : w_take ? r_ret_pc + WORD_BYTES : r_ret_pc;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      assert (w_outst_nxt <= MAXC && !(imem_rvalid && r_outst == '0));
      assert (w_squash_nxt <= w_outst_nxt);
    end
endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: directed and randomized checks of arm_fetch against an in-order memory and a sequential-PC decoder model.
module tb_arm_fetch;
`ifdef ARM_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  int n_cmp = 0, n_err = 0, cyc = 0, n_pop = 0, n_grant = 0, base;
  bit rnd = 1'b0, mem_hold = 1'b0, stall = 1'b0;
  logic [31:0] exp_pc = '0, stall_pc = '0, stall_inst = '0;
  logic [31:0] pa[$];
  int pd[$];
  logic [31:0] seen[$];

  arm_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Drive the memory side for this cycle and let combinational outputs settle.
  task automatic settle();
    imem_gnt = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (!mem_hold && pa.size() > 0 && pd[0] <= cyc && (!rnd || $urandom_range(0, 2) != 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(pa[0]);
    end
    #1;
    if (stall && !reset) begin
      chk("hold_pc", inst_pc, stall_pc);
      chk("hold_inst", inst, stall_inst);
      if (!redirect_valid) chk("hold_valid", 32'(inst_valid), 32'd1);
    end
  endtask

  // Score the decoder handshake and memory traffic, then advance one clock.
  task automatic tick();
    if (!reset) begin
      if (redirect_valid) chk("redir_valid0", 32'(inst_valid), 32'd0);
      if (inst_valid && inst_ready) begin
        chk("pop_pc", inst_pc, exp_pc);
        chk("pop_inst", inst, mem_word(exp_pc));
        seen.push_back(inst_pc);
        exp_pc += 32'd4;
        n_pop++;
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        seen.delete();
      end
      if (imem_req && imem_gnt) begin
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        pa.push_back(imem_addr);
        pd.push_back(cyc + 1);
        n_grant++;
      end
      if (imem_rvalid && pa.size() > 0) begin
        void'(pa.pop_front());
        void'(pd.pop_front());
      end
      stall = inst_valid && !inst_ready && !redirect_valid;
      stall_pc = inst_pc;
      stall_inst = inst;
    end else begin
      pa.delete();
      pd.delete();
      seen.delete();
      exp_pc = '0;
      stall = 1'b0;
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    // Reset values
    cycle();
    settle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    tick();
    // 1: streaming with 1-cycle memory latency
    reset = 1'b0;
    inst_ready = 1'b1;
    settle();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_valid_c0", 32'(inst_valid), 32'd0);
    tick();
    settle();
    chk("t1_valid_c1", 32'(inst_valid), 32'(BYP));
    tick();
    settle();
    chk("t1_valid_c2", 32'(inst_valid), 32'd1);
    tick();
    repeat (10) cycle();
    chk("t1_pops", 32'(n_pop >= 8), 32'd1);
    chk("t1_first_pc", seen[0], 32'h0);
    // 2: decoder stalled from reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    inst_ready = 1'b0;
    n_grant = 0;
    repeat (10) cycle();
    settle();
    chk("t2_grants", 32'(n_grant), 32'd4);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_head_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0);
    tick();
    inst_ready = 1'b1;
    base = n_pop;
    repeat (12) cycle();
    chk("t2_resume", 32'(n_pop - base >= 4), 32'd1);
    // 3: redirect with three reads in flight
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mem_hold = 1'b1;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    settle();
    chk("t3_req_masked", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("t3_drain_req", 32'(imem_req), 32'd0);
    chk("t3_drain_addr", imem_addr, 32'h0000_1000);
    tick();
    mem_hold = 1'b0;
    repeat (15) cycle();
    chk("t3_got", 32'(seen.size() > 3), 32'd1);
    chk("t3_first_pc", seen[0], 32'h0000_1000);
    // 4: redirect colliding with a decoder pop
    settle();
    chk("t4_pre_valid", 32'(inst_valid), 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    cycle();
    redirect_valid = 1'b0;
    settle();
    chk("t4_valid_next", 32'(inst_valid), 32'd0);
    tick();
    repeat (10) cycle();
    chk("t4_got", 32'(seen.size() > 0), 32'd1);
    chk("t4_first_pc", seen[0], 32'h0000_2000);
    // 5: address wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    repeat (10) cycle();
    chk("t5_count", 32'(seen.size() >= 3), 32'd1);
    if (seen.size() >= 3) begin
      chk("t5_pc0", seen[0], 32'hFFFF_FFF8);
      chk("t5_pc1", seen[1], 32'hFFFF_FFFC);
      chk("t5_pc2", seen[2], 32'h0000_0000);
    end
    // 6: reset with buffered words and reads in flight
    inst_ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    inst_ready = 1'b1;
    settle();
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", 32'(imem_req), 32'd1);
    tick();
    repeat (12) cycle();
    chk("t6_first_pc", seen[0], 32'h0);
    // Randomized grants, latencies, back-pressure and redirects
    rnd = 1'b1;
    base = n_pop;
    for (int i = 0; i < 500; i++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc = $urandom;
      cycle();
    end
    rnd = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (20) cycle();
    chk("rnd_progress", 32'(n_pop - base > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
